// File: rtl/pulse_stretcher_multi.sv
// Multi-channel pulse stretcher: per-channel run-time length, retrigger and
// edge/level trigger modes, plus a sticky flag for triggers that were ignored.
module pulse_stretcher_multi #(
   parameter int              NCHAN              = 4,
   parameter longint unsigned CLK_FREQUENCY      = 100000000,
   parameter longint unsigned DEFAULT_STRETCH_MS = 100,
   parameter int              LEN_WIDTH          = 32
) (
   input  logic                 clk,
   input  logic                 rst_a_n,
   input  logic [NCHAN-1:0]     pulse,
   input  logic [NCHAN-1:0]     retrigMode,
   input  logic [NCHAN-1:0]     edgeMode,
   input  logic                 cfgWrite,
   input  logic [4:0]           cfgChannel,
   input  logic [LEN_WIDTH-1:0] cfgLen,
   output logic [LEN_WIDTH-1:0] cfgReadback,
   input  logic [NCHAN-1:0]     missedClear,
   output logic [NCHAN-1:0]     pulseStretch,
   output logic [NCHAN-1:0]     missed
);

   localparam longint unsigned DEFAULT_LEN_FULL = CLK_FREQUENCY / 64'd1000 * DEFAULT_STRETCH_MS;
   localparam logic [LEN_WIDTH-1:0] DEFAULT_LEN = LEN_WIDTH'(DEFAULT_LEN_FULL);

   if (LEN_WIDTH < 64 && DEFAULT_LEN_FULL >= (64'd1 << LEN_WIDTH)) begin : g_len_check
      $error("DEFAULT_LEN does not fit in LEN_WIDTH bits");
   end

   logic [LEN_WIDTH-1:0] len_q [NCHAN];
   logic [LEN_WIDTH-1:0] cnt_q [NCHAN];
   logic [NCHAN-1:0]     pulse_d;
   logic [NCHAN-1:0]     trig;
   logic [NCHAN-1:0]     accept;
   logic [NCHAN-1:0]     miss_set;
   logic [NCHAN-1:0]     cfg_hit;
   logic [LEN_WIDTH-1:0] readback_next;

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      trig          = '0;
      accept        = '0;
      miss_set      = '0;
      cfg_hit       = '0;
      readback_next = '0;
      for (int i = 0; i < NCHAN; i++) begin
         trig[i]     = edgeMode[i] ? (pulse[i] & ~pulse_d[i]) : pulse[i];
         // The falling cycle still has pulseStretch high, so a trigger there is missed too.
         accept[i]   = trig[i] & (retrigMode[i] | ~pulseStretch[i]) & (len_q[i] != '0);
         miss_set[i] = trig[i] & ~retrigMode[i] & pulseStretch[i] & (len_q[i] != '0);
         cfg_hit[i]  = cfgWrite & (cfgChannel == 5'(i));
         if (cfgChannel == 5'(i)) begin
            readback_next = len_q[i];
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) begin
         pulse_d      <= '0;
         pulseStretch <= '0;
         missed       <= '0;
         cfgReadback  <= DEFAULT_LEN;
         // NOTE: the length/counter arrays are small register files, so they are reset like flops.
         for (int i = 0; i < NCHAN; i++) begin
            len_q[i] <= DEFAULT_LEN;
            cnt_q[i] <= '0;
         end
      end else begin
         pulse_d     <= pulse;
         cfgReadback <= readback_next;
         missed      <= (missed & ~missedClear) | miss_set;
         for (int i = 0; i < NCHAN; i++) begin
            // A trigger in the same cycle as a write still loads from the old length.
            if (cfg_hit[i]) begin
               len_q[i] <= cfgLen;
            end
            if (accept[i]) begin
               pulseStretch[i] <= 1'b1;
               cnt_q[i]        <= len_q[i] - LEN_WIDTH'(1);
            end else if (cnt_q[i] != '0) begin
               cnt_q[i] <= cnt_q[i] - LEN_WIDTH'(1);
            end else begin
               pulseStretch[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pulse_stretcher_multi.sv
// Bench for pulse_stretcher_multi: directed corner cases plus random traffic,
// compared every cycle against a remaining-cycles model of each channel.
module tb_pulse_stretcher_multi;

   localparam int NCHAN   = 4;
   localparam int LW      = 32;
   localparam int DEF_LEN = 1000;

   logic             clk       = 1'b0;
   logic             rst_a_n   = 1'b0;
   logic [NCHAN-1:0] pulse     = '0;
   logic [NCHAN-1:0] retrig    = '0;
   logic [NCHAN-1:0] edge_m    = '1;
   logic [NCHAN-1:0] mclr      = '0;
   logic             cfg_write = 1'b0;
   logic [4:0]       cfg_ch    = '0;
   logic [LW-1:0]    cfg_len   = '0;
   logic [LW-1:0]    cfg_readback;
   logic [NCHAN-1:0] pulse_stretch;
   logic [NCHAN-1:0] missed;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // Model: m_rem is how many more cycles the output stays high.
   int               m_len [NCHAN];
   int               m_rem [NCHAN];
   logic [NCHAN-1:0] m_prev;
   logic [NCHAN-1:0] m_missed;
   int               m_rb;
   int               hi_cnt [NCHAN] = '{default: 0};

   pulse_stretcher_multi #(
      .NCHAN(NCHAN),
      .CLK_FREQUENCY(1000000),
      .DEFAULT_STRETCH_MS(1),
      .LEN_WIDTH(LW)
   ) dut (
      .clk(clk),
      .rst_a_n(rst_a_n),
      .pulse(pulse),
      .retrigMode(retrig),
      .edgeMode(edge_m),
      .cfgWrite(cfg_write),
      .cfgChannel(cfg_ch),
      .cfgLen(cfg_len),
      .cfgReadback(cfg_readback),
      .missedClear(mclr),
      .pulseStretch(pulse_stretch),
      .missed(missed)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCHAN; i++) begin
         m_len[i] = DEF_LEN;
         m_rem[i] = 0;
      end
      m_prev   = '0;
      m_missed = '0;
      m_rb     = DEF_LEN;
   endtask

   task automatic model_step();
      logic t;
      m_rb = 0;
      for (int i = 0; i < NCHAN; i++) begin
         if (int'(cfg_ch) == i) m_rb = m_len[i];
      end
      for (int i = 0; i < NCHAN; i++) begin
         t = edge_m[i] ? (pulse[i] && !m_prev[i]) : pulse[i];
         if (t && !retrig[i] && m_rem[i] > 0 && m_len[i] != 0) m_missed[i] = 1'b1;
         else if (mclr[i]) m_missed[i] = 1'b0;
         if (t && (retrig[i] || m_rem[i] == 0) && m_len[i] != 0) m_rem[i] = m_len[i];
         else if (m_rem[i] > 0) m_rem[i] = m_rem[i] - 1;
         if (cfg_write && int'(cfg_ch) == i) m_len[i] = int'(cfg_len);
      end
      m_prev = pulse;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_a_n) model_step();
      #2;
      cfg_write = 1'b0;
      mclr      = '0;
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) tick();
   endtask

   task automatic cfg(input int ch, input int len);
      cfg_write = 1'b1;
      cfg_ch    = 5'(ch);
      cfg_len   = LW'(len);
      tick();
   endtask

   task automatic pulse_seq(input int ch, input int n, input logic [31:0] mask);
      for (int c = 0; c < n; c++) begin
         pulse[ch] = mask[c];
         tick();
      end
      pulse[ch] = 1'b0;
   endtask

   always @(negedge clk) begin
      logic [NCHAN-1:0] exp_ps;
      for (int i = 0; i < NCHAN; i++) begin
         exp_ps[i] = (m_rem[i] > 0);
         hi_cnt[i] += int'(pulse_stretch[i]);
      end
      if (chk_en) begin
         check("pulseStretch", 64'(pulse_stretch), 64'(exp_ps));
         check("missed", 64'(missed), 64'(m_missed));
         check("cfgReadback", 64'(cfg_readback), 64'(m_rb));
      end
   end

   initial begin
      int snap;
      model_reset();
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #3 rst_a_n = 1'b1;

      for (int i = 0; i < NCHAN; i++) begin
         cfg_ch = 5'(i);
         tick();
         check("reset_readback", 64'(cfg_readback), 64'(DEF_LEN));
      end

      // Default length, single edge on ch0.
      snap = hi_cnt[0];
      pulse_seq(0, 1, 32'h1);
      idle(1005);
      check("default_len_high", 64'(hi_cnt[0] - snap), 64'd1000);

      // Retriggerable, edge mode, pulses at 0 and 3.
      cfg(1, 5);
      retrig[1] = 1'b1;
      edge_m[1] = 1'b1;
      snap = hi_cnt[1];
      pulse_seq(1, 12, 32'h9);
      check("retrig_high", 64'(hi_cnt[1] - snap), 64'd8);
      check("retrig_missed", 64'(missed[1]), 64'd0);

      // Non-retriggerable, level mode, pulses at 0,3,5,6 then ignored one at 8.
      cfg(2, 5);
      retrig[2] = 1'b0;
      edge_m[2] = 1'b0;
      snap = hi_cnt[2];
      pulse_seq(2, 8, 32'h69);
      check("nonretrig_missed_set", 64'(missed[2]), 64'd1);
      pulse[2] = 1'b1;
      mclr[2]  = 1'b1;
      tick();
      pulse[2] = 1'b0;
      check("missed_set_wins", 64'(missed[2]), 64'd1);
      idle(6);
      check("nonretrig_high", 64'(hi_cnt[2] - snap), 64'd10);
      mclr[2] = 1'b1;
      tick();
      check("missed_clear", 64'(missed[2]), 64'd0);

      // Level vs edge mode with a 10-cycle held pulse.
      cfg(1, 4);
      edge_m[1] = 1'b0;
      snap = hi_cnt[1];
      pulse_seq(1, 16, 32'h3FF);
      check("level_held_high", 64'(hi_cnt[1] - snap), 64'd13);
      edge_m[1] = 1'b1;
      snap = hi_cnt[1];
      pulse_seq(1, 16, 32'h3FF);
      check("edge_held_high", 64'(hi_cnt[1] - snap), 64'd4);

      // Disabled channel.
      cfg(3, 0);
      retrig[3] = 1'b0;
      edge_m[3] = 1'b1;
      snap = hi_cnt[3];
      pulse_seq(3, 8, 32'h25);
      check("len0_high", 64'(hi_cnt[3] - snap), 64'd0);
      check("len0_missed", 64'(missed[3]), 64'd0);

      // Length write mid-stretch applies to the next trigger only.
      cfg(0, 5);
      snap = hi_cnt[0];
      pulse_seq(0, 2, 32'h1);
      cfg(0, 7);
      idle(5);
      check("midwrite_old_len", 64'(hi_cnt[0] - snap), 64'd5);
      snap = hi_cnt[0];
      pulse_seq(0, 1, 32'h1);
      idle(10);
      check("midwrite_new_len", 64'(hi_cnt[0] - snap), 64'd7);

      // Out-of-range channel.
      cfg(NCHAN, 99);
      cfg_ch = 5'(NCHAN);
      tick();
      check("oob_readback", 64'(cfg_readback), 64'd0);
      cfg_ch = 5'd1;
      tick();
      check("oob_no_write", 64'(cfg_readback), 64'd4);

      // Async reset mid-stretch, between clock edges.
      pulse_seq(2, 3, 32'h7);
      pulse_seq(0, 1, 32'h1);
      idle(2);
      check("pre_reset_stretch", 64'(pulse_stretch[0]), 64'd1);
      check("pre_reset_missed", 64'(missed[2]), 64'd1);
      #1 rst_a_n = 1'b0;
      model_reset();
      #1;
      check("async_reset_stretch", 64'(pulse_stretch), 64'd0);
      check("async_reset_missed", 64'(missed), 64'd0);
      check("async_reset_readback", 64'(cfg_readback), 64'(DEF_LEN));
      @(posedge clk);
      @(posedge clk);
      #3 rst_a_n = 1'b1;
      for (int i = 0; i < NCHAN; i++) begin
         cfg_ch = 5'(i);
         tick();
         check("post_reset_len", 64'(cfg_readback), 64'(DEF_LEN));
      end

      // Random traffic with short lengths.
      for (int i = 0; i < NCHAN; i++) cfg(i, 3 + i);
      for (int c = 0; c < 3000; c++) begin
         if (c % 64 == 0) begin
            retrig = NCHAN'($urandom);
            edge_m = NCHAN'($urandom);
         end
         pulse     = NCHAN'($urandom & $urandom);
         cfg_write = ($urandom_range(0, 15) == 0);
         cfg_ch    = 5'($urandom_range(0, 7));
         cfg_len   = LW'($urandom_range(0, 12));
         mclr      = ($urandom_range(0, 7) == 0) ? NCHAN'($urandom) : '0;
         tick();
      end
      pulse = '0;
      idle(20);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pulse_stretcher_multi.md
Name: pulse_stretcher_multi

Overview:
- Multi-channel pulse stretcher with stretch length, retrigger mode and edge/level trigger mode programmable per channel at run time.
- Extends the single-channel fixed-length stretcher and adds a sticky "missed trigger" flag for each channel.
- Used for front-panel LEDs, interlock indications and diagnostic strobes.
- All channels share one clock domain.

Parameters:
- NCHAN, 4: number of independent channels (1..32).
- CLK_FREQUENCY, 100000000: clock frequency in Hz, used only to compute the reset-default length.
- DEFAULT_STRETCH_MS, 100: reset-default stretch for every channel. DEFAULT_LEN = CLK_FREQUENCY/1000*DEFAULT_STRETCH_MS cycles.
- LEN_WIDTH, 32: width of the length registers and counters. Elaboration fails if DEFAULT_LEN >= 2**LEN_WIDTH.

Ports:
- clk  in  1  system clock.
- rst_a_n  in  1  reset, active-low.
- pulse  in  NCHAN  per-channel trigger inputs, synchronous to clk.
- retrigMode  in  NCHAN  1 = retriggerable, 0 = triggers ignored while stretching; static or quasi-static.
- edgeMode  in  NCHAN  1 = trigger on rising edge of pulse, 0 = trigger on every cycle pulse is high.
- cfgWrite  in  1  one-cycle strobe; loads cfgLen into the length register of channel cfgChannel.
- cfgChannel  in  5  channel select for write and readback.
- cfgLen  in  LEN_WIDTH  stretch length in clock cycles.
- cfgReadback  out  LEN_WIDTH  registered length of channel cfgChannel.
- missedClear  in  NCHAN  per-bit clear strobe for missed.
- pulseStretch  out  NCHAN  stretched outputs, registered.
- missed  out  NCHAN  sticky: a trigger was ignored in non-retriggerable mode.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_a_n is asynchronous, active-low; assertion takes effect immediately, deassertion is synchronous to clk.
- Reset values:
  - pulseStretch = 0, missed = 0.
  - All counters = 0, all edge-history registers = 0.
  - All length registers = DEFAULT_LEN; cfgReadback = DEFAULT_LEN.
  - Reset mid-stretch terminates the output immediately.
- Trigger derivation, per channel:
  - trig = pulse & ~pulse_d when edgeMode = 1; trig = pulse when edgeMode = 0.
  - pulse_d is pulse registered once.
  - pulse high in the first cycle after reset counts as a rising edge.
- Accepted trigger: trig & (retrigMode | ~pulseStretch) & (len != 0).
- On an accepted trigger at edge k:
  - pulseStretch = 1 from edge k.
  - counter loads len-1.
- Each later cycle with no accepted trigger:
  - if counter != 0, decrement it;
  - else pulseStretch <= 0.
- Output length: an isolated trigger gives exactly len cycles of pulseStretch = 1. Latency from pulse to pulseStretch is one cycle (registered).
- Retriggerable mode:
  - an accepted trigger while stretching reloads the counter;
  - the output stays high until len cycles after the last trigger.
  - In level mode, a held pulse keeps the output high continuously.
- Non-retriggerable mode:
  - a trig while pulseStretch = 1 is ignored and sets missed.
  - A trig in the same cycle the output falls (counter = 0, pulseStretch = 1) is also ignored and missed. The next trigger can be accepted only once pulseStretch = 0.
- len = 0: channel disabled. Triggers are ignored, missed is not set, output stays 0.
- Length writes:
  - A cfgWrite takes effect at the next edge.
  - A stretch in progress keeps its loaded counter; the new len applies from the next accepted trigger.
  - A write and a trigger on the same channel in the same cycle: the trigger uses the old len.
  - A write with cfgChannel >= NCHAN is ignored.
- cfgReadback: registered copy of len[cfgChannel], updated every cycle (one-cycle latency). Returns 0 for cfgChannel >= NCHAN.
- missed: a set and a missedClear in the same cycle leave missed = 1 (set wins).
- Counters never wrap: decrement only when nonzero.
- Channels are fully independent. A mode-bit change mid-stretch does not alter the current counter.

Test Plan:
- Reset values: CLK_FREQUENCY = 1000000, DEFAULT_STRETCH_MS = 1, check cfgReadback = 1000 for each channel after reset. Single edge pulse on ch0 with default length -> pulseStretch[0] high exactly 1000 cycles, starting one cycle after the pulse.
- Retrigger: write len = 5 to ch1, retrigMode = 1, edgeMode = 1; pulses at cycles 0 and 3 -> output high cycles 1..8 (8 cycles), missed[1] = 0.
- Non-retrigger: len = 5 on ch2, retrigMode = 0; pulses at cycles 0, 3 and 5 -> output high cycles 1..5; missed[2] = 1; pulse at 6 accepted (high 7..11); missedClear together with a new ignored trigger -> missed stays 1.
- Level mode: edgeMode = 0, len = 4, pulse held high 10 cycles -> output high 10 + 3 = 13 cycles. Same stimulus with edgeMode = 1 -> output high 4 cycles.
- Config corner cases:
  - write len = 0 to ch3 -> triggers produce no output, missed[3] = 0;
  - write len = 7 mid-stretch of len = 5 -> current pulse lasts 5, next lasts 7;
  - write to channel NCHAN -> no state change.
- Async reset: assert rst_a_n low mid-stretch, between clock edges -> pulseStretch drops immediately, lengths return to 1000, missed cleared.
